alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered successor to the Hack combinational ALU. It supports the full six-control-bit Hack function set at any data width and adds an optional iterative multiply. Operands enter and results leave through valid/ready handshakes. Results and flags are registered, so the block sits between the CPU decode stage and the writeback/register-file stage.

## Interface
- WIDTH, 16, datapath width in bits; legal values are WIDTH >= 2.
- i_Clk  in  1  system clock; all state changes on the rising edge.
- i_RstN  in  1  asynchronous, active-low reset.
- i_Valid  in  1  request valid.
- o_Ready  out  1  block can accept a request this cycle.
- i_X, i_Y  in  WIDTH  operands.
- i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO  in  1 each  Hack control bits.
- i_Mul  in  1  multiply request; only present with ALU_MUL_EN.
- o_Valid  out  1  result valid.
- i_Ready  in  1  downstream accepts the result.
- o_ALU  out  WIDTH  registered result.
- o_ZR  out  1  o_ALU == 0.
- o_NG  out  1  o_ALU[WIDTH-1].
- o_Busy  out  1  multiply in progress.

## Operation
- A request is accepted on a rising edge where i_Valid && o_Ready. Operands and control bits are latched at that edge; later input changes are ignored until the next accept.
- Operand preprocessing: x' = ZX ? 0 : X, then NX ? ~x' : x'. Same for y' with ZY/NY.
- Hack op (i_Mul=0): f = F ? (x' + y') : (x' & y'). Result = NO ? ~f : f. Addition wraps modulo 2^WIDTH; carry is discarded.
- Multiply (i_Mul=1): shift-add, one multiplier bit per cycle, LSB first.
  - Product is the low WIDTH bits of x'*y'; this is identical for signed and unsigned.
  - i_F is ignored. NO inverts the final product.
- o_ZR and o_NG are derived from the registered o_ALU and always match it.
- State machine:
  - IDLE: o_Ready=1. Accept of a Hack op goes to DONE; accept of a multiply goes to MUL with counter = 0.
  - MUL: o_Ready=0, o_Busy=1. The counter increments each cycle. When the counter reaches WIDTH-1, the final product (with NO applied) is loaded into o_ALU and the state goes to DONE.
  - DONE: o_Valid=1; o_ALU and the flags are held stable.
    - i_Ready=0: stay in DONE; o_Ready=0.
    - i_Ready=1: o_Ready=1. A simultaneous accept starts the next operation (Hack op: stay in DONE with the new result; multiply: go to MUL). With no accept, go to IDLE.
- o_Valid stays asserted until the result is consumed; the result is never dropped or overwritten while unconsumed.
- Reset asserted at any time, including mid-multiply:
  - State returns to IDLE immediately and any partial product is discarded.
  - Outputs: o_Valid=0, o_ALU=0, o_ZR=1, o_NG=0, o_Busy=0, o_Ready=1 (while reset is asserted and after release).

## Timing
- Hack op latency: 1 cycle. o_Valid is high starting the cycle after the accept edge.
- Multiply latency: WIDTH cycles from the accept edge to o_Valid (16 at the default width).
- Throughput: one Hack op per cycle while i_Valid and i_Ready are both held high. Multiply throughput is one per WIDTH+1 cycles (WIDTH cycles in MUL plus one in DONE) when back-to-back.
- o_Ready depends combinationally on i_Ready (DONE state only). There is no other input-to-output combinational path.

## Configuration
- ALU_MUL_EN defined:
  - i_Mul port, MUL state, counter, and shift-add datapath are present.
- ALU_MUL_EN undefined:
  - i_Mul port is absent and all operations are Hack ops with 1-cycle latency.
  - o_Busy is tied to 0 and the MUL state does not exist.

## Test plan
- Reset: assert i_RstN=0 mid-stream -> o_Valid=0, o_ALU=0, o_ZR=1, o_NG=0, o_Ready=1.
- Add, WIDTH=16: X=5, Y=3, controls 000010 (ZX NX ZY NY F NO) -> o_ALU=0x0008 one cycle later, ZR=0, NG=0. X-Y: X=3, Y=5, controls 010011 -> o_ALU=0xFFFE, NG=1.
- Backpressure: hold i_Ready=0 for 5 cycles after a result -> o_ALU stable, o_Ready=0, new request not accepted. Raise i_Ready -> result consumed and the pending request accepted on the same edge.
- Streaming: 8 back-to-back Hack ops with i_Valid=i_Ready=1 -> 8 consecutive o_Valid cycles, results in order.
- Multiply (ALU_MUL_EN): X=7, Y=6, i_Mul=1 -> o_Busy high and o_Ready low for 16 cycles, then o_ALU=0x002A. X=0x0100, Y=0x0100 -> o_ALU=0x0000, ZR=1. X=0xFFFF, Y=2, NO=1 -> o_ALU=0x0001.
- Reset at multiply cycle 8 -> IDLE, no o_Valid. A following add X=1, Y=1 -> o_ALU=0x0002 after 1 cycle.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered, parametrised successor to the Hack combinational ALU.
// Requests and results use valid/ready handshakes. The result and its flags
// are held in registers until they are consumed downstream.
// Define ALU_MUL_EN to build in the iterative shift-add multiply (i_Mul port,
// MUL state, bit counter). Without it every operation is a 1-cycle Hack op.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_RstN,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_X,
    input  logic [WIDTH-1:0] i_Y,
    input  logic             i_ZX,
    input  logic             i_NX,
    input  logic             i_ZY,
    input  logic             i_NY,
    input  logic             i_F,
    input  logic             i_NO,
`ifdef ALU_MUL_EN
    input  logic             i_Mul,
`endif
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_ALU,
    output logic             o_ZR,
    output logic             o_NG,
    output logic             o_Busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd1;
`ifdef ALU_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam int         CNT_W   = $clog2(WIDTH);
`endif

    logic [1:0]       state;
    logic             accept;
    logic [WIDTH-1:0] x_pre;
    logic [WIDTH-1:0] y_pre;
    logic [WIDTH-1:0] hack_res;

    // Operand preprocessing and the Hack function on the live request inputs.
    // NOTE: every variable gets a full default before any conditional update,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        x_pre = i_ZX ? '0 : i_X;
        if (i_NX) x_pre = ~x_pre;
        y_pre = i_ZY ? '0 : i_Y;
        if (i_NY) y_pre = ~y_pre;
        hack_res = i_F ? (x_pre + y_pre) : (x_pre & y_pre);
        if (i_NO) hack_res = ~hack_res;
    end

    // Handshake: a held result blocks new work until downstream takes it.
    assign o_Valid = (state == ST_DONE);
    assign o_Ready = (state == ST_IDLE) || ((state == ST_DONE) && i_Ready);
    assign accept  = i_Valid && o_Ready;

    // Flags always follow the registered result.
    assign o_ZR = (o_ALU == '0);
    assign o_NG = o_ALU[WIDTH-1];

`ifdef ALU_MUL_EN
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_res;
    logic             mul_no;

    assign o_Busy = (state == ST_MUL);

    // Final product: fold in the last multiplier bit, then apply NO.
    always_comb begin
        mul_res = acc + (mplier[0] ? mcand : '0);
        if (mul_no) mul_res = ~mul_res;
    end

    // Shift-add datapath: one multiplier bit per cycle, LSB first.
    // NOTE: these operand registers carry no reset; they are always loaded on
    // the accept edge before MUL reads them, and an aborted multiply is simply
    // never read again.
    always_ff @(posedge i_Clk) begin
        if (accept && i_Mul) begin
            mcand  <= x_pre;
            mplier <= y_pre;
            acc    <= '0;
            mul_no <= i_NO;
        end else if (state == ST_MUL) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`else
    assign o_Busy = 1'b0;
`endif

    // Control FSM and result register; reset abandons any operation in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            state <= ST_IDLE;
            o_ALU <= '0;
`ifdef ALU_MUL_EN
            cnt   <= '0;
`endif
        end else begin
            case (state)
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        o_ALU <= mul_res;
                        state <= ST_DONE;
                    end
                end
`endif
                default: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (i_Mul) begin
                            state <= ST_MUL;
                            cnt   <= '0;
                        end else
`endif
                        begin
                            state <= ST_DONE;
                            o_ALU <= hack_res;
                        end
                    end else if (o_Valid && i_Ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed stimulus for alu_pipe, checked every
// cycle against a transaction-level model (pending result plus multiply
// countdown), with a few literal expectations from hand arithmetic.
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit HAS_MUL = 1'b1;
`else
    localparam bit HAS_MUL = 1'b0;
`endif

    logic         i_Clk = 1'b0;
    logic         i_RstN;
    logic         i_Valid;
    logic         i_Ready;
    logic         i_Mul;
    logic [W-1:0] i_X;
    logic [W-1:0] i_Y;
    logic         i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO;
    logic         o_Ready, o_Valid, o_ZR, o_NG, o_Busy;
    logic [W-1:0] o_ALU;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .i_Clk   (i_Clk),
        .i_RstN  (i_RstN),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_X     (i_X),
        .i_Y     (i_Y),
        .i_ZX    (i_ZX),
        .i_NX    (i_NX),
        .i_ZY    (i_ZY),
        .i_NY    (i_NY),
        .i_F     (i_F),
        .i_NO    (i_NO),
`ifdef ALU_MUL_EN
        .i_Mul   (i_Mul),
`endif
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_ALU   (o_ALU),
        .o_ZR    (o_ZR),
        .o_NG    (o_NG),
        .o_Busy  (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] pre(input logic [W-1:0] v, input logic z, input logic n);
        logic [W-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    function automatic logic [W-1:0] ref_hack(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [5:0] c);
        logic [W-1:0] a, b, f;
        a = pre(x, c[5], c[4]);
        b = pre(y, c[3], c[2]);
        f = c[1] ? W'(a + b) : (a & b);
        return c[0] ? ~f : f;
    endfunction

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [5:0] c);
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;
        a = pre(x, c[5], c[4]);
        b = pre(y, c[3], c[2]);
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return c[0] ? ~p[W-1:0] : p[W-1:0];
    endfunction

    // ---------------- transaction model ----------------
    bit           m_valid;
    int           m_busy;
    logic [W-1:0] m_res;
    logic [W-1:0] m_mul_res;

    // Model advance on each clock; reset empties it.
    always @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            m_valid <= 1'b0;
            m_busy  <= 0;
        end else begin : step
            bit           n_valid;
            bit           take;
            int           n_busy;
            logic [W-1:0] n_res;
            logic [W-1:0] n_mul;
            logic [5:0]   c;
            c       = {i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO};
            n_valid = m_valid;
            n_busy  = m_busy;
            n_res   = m_res;
            n_mul   = m_mul_res;
            take    = i_Valid && (m_busy == 0) && (!m_valid || i_Ready);
            if (m_busy > 0) begin
                n_busy = m_busy - 1;
                if (n_busy == 0) begin
                    n_valid = 1'b1;
                    n_res   = m_mul_res;
                end
            end else if (m_valid && i_Ready) begin
                n_valid = 1'b0;
            end
            if (take) begin
                if (HAS_MUL && i_Mul) begin
                    n_busy  = W;
                    n_valid = 1'b0;
                    n_mul   = ref_mul(i_X, i_Y, c);
                end else begin
                    n_valid = 1'b1;
                    n_res   = ref_hack(i_X, i_Y, c);
                end
            end
            m_valid   <= n_valid;
            m_busy    <= n_busy;
            m_res     <= n_res;
            m_mul_res <= n_mul;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge i_Clk) begin
        if (!i_RstN) begin
            check("reset_valid", o_Valid, 1'b0);
            check("reset_alu", o_ALU, '0);
            check("reset_zr", o_ZR, 1'b1);
            check("reset_ng", o_NG, 1'b0);
            check("reset_busy", o_Busy, 1'b0);
            check("reset_ready", o_Ready, 1'b1);
        end else begin
            check("ready", o_Ready, (m_busy == 0) && (!m_valid || i_Ready));
            check("valid", o_Valid, m_valid);
            check("busy", o_Busy, m_busy > 0);
            if (m_valid) begin
                check("alu", o_ALU, m_res);
                check("zr", o_ZR, m_res == '0);
                check("ng", o_NG, m_res[W-1]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic look();
        @(negedge i_Clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [5:0] c, input bit mul, input bit rdy);
        i_Valid = v;
        i_X     = x;
        i_Y     = y;
        {i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO} = c;
        i_Mul   = mul;
        i_Ready = rdy;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

`ifdef ALU_MUL_EN
    // Issue one multiply, count busy cycles until the result appears.
    task automatic mul_run(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [5:0] c, input logic [W-1:0] exp);
        int nb;
        drive(1, x, y, c, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        nb = 0;
        look();
        while (!o_Valid && nb < 100) begin
            if (o_Busy && !o_Ready) nb++;
            tick();
            look();
        end
        check({name, "_done"}, o_Valid, 1'b1);
        check({name, "_cycles"}, nb, W);
        check({name, "_alu"}, o_ALU, exp);
    endtask
`endif

    // ---------------- test sequence ----------------
    initial begin
        int nv;
        i_RstN = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        repeat (3) tick();
        i_RstN = 1'b1;
        look();
        check("init_alu", o_ALU, 16'h0000);
        check("init_zr", o_ZR, 1'b1);
        check("init_ready", o_Ready, 1'b1);
        check("init_valid", o_Valid, 1'b0);

        // Add 5+3, then hold the result under backpressure with X-Y pending.
        drive(1, 16'd5, 16'd3, 6'b000010, 0, 0);
        tick();
        drive(1, 16'd3, 16'd5, 6'b010011, 0, 0);
        look();
        check("add_valid", o_Valid, 1'b1);
        check("add_alu", o_ALU, 16'h0008);
        check("add_zr", o_ZR, 1'b0);
        check("add_ng", o_NG, 1'b0);
        repeat (5) begin
            check("bp_ready", o_Ready, 1'b0);
            check("bp_alu", o_ALU, 16'h0008);
            tick();
            look();
        end
        i_Ready = 1'b1;
        #1;
        check("bp_release_ready", o_Ready, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        look();
        check("sub_alu", o_ALU, 16'hFFFE);
        check("sub_ng", o_NG, 1'b1);
        check("sub_zr", o_ZR, 1'b0);
        tick();
        look();
        check("sub_consumed", o_Valid, 1'b0);

        // Streaming: 8 back-to-back Hack ops.
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, rand_operand(), rand_operand(), 6'($urandom), 0, 1);
            tick();
            look();
            if (o_Valid) nv++;
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        look();
        check("stream_count", nv, 8);
        check("stream_end", o_Valid, 1'b0);

        // Reset mid-stream with a held result.
        drive(1, 16'd9, 16'd9, 6'b000010, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        look();
        i_RstN = 1'b0;
        #1;
        check("midrst_valid", o_Valid, 1'b0);
        check("midrst_alu", o_ALU, 16'h0000);
        check("midrst_ready", o_Ready, 1'b1);
        tick();
        i_RstN = 1'b1;

`ifdef ALU_MUL_EN
        mul_run("mul_7x6", 16'd7, 16'd6, 6'b000010, 16'h002A);
        tick();
        mul_run("mul_sq", 16'h0100, 16'h0100, 6'b000000, 16'h0000);
        check("mul_sq_zr", o_ZR, 1'b1);
        tick();
        mul_run("mul_no", 16'hFFFF, 16'd2, 6'b000001, 16'h0001);
        tick();

        // Reset at multiply cycle 8: nothing may emerge afterwards.
        drive(1, 16'd7, 16'd6, 6'b000010, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        repeat (8) tick();
        check("mulrst_busy_before", o_Busy, 1'b1);
        i_RstN = 1'b0;
        #1;
        check("mulrst_busy", o_Busy, 1'b0);
        check("mulrst_ready", o_Ready, 1'b1);
        check("mulrst_valid", o_Valid, 1'b0);
        tick();
        i_RstN = 1'b1;
        nv = 0;
        repeat (20) begin
            look();
            if (o_Valid) nv++;
        end
        check("mulrst_no_valid", nv, 0);
`endif

        // Add 1+1 after reset.
        drive(1, 16'd1, 16'd1, 6'b000010, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        look();
        check("post_rst_add", o_ALU, 16'h0002);
        check("post_rst_valid", o_Valid, 1'b1);
        tick();

        // Randomized traffic with random backpressure and rare resets.
        repeat (3000) begin
            drive($urandom_range(0, 3) != 0, rand_operand(), rand_operand(), 6'($urandom),
                  HAS_MUL && ($urandom_range(0, 7) == 0), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                i_RstN = 1'b0;
                tick();
                i_RstN = 1'b1;
            end else begin
                tick();
            end
        end

        drive(0, 0, 0, 0, 0, 1);
        tick();
        look();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
